// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command sender (inhibit, RTS, 8 data bits, odd parity, stop, ACK check)
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_pull,
  output logic       ps2_data_pull,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, DATA, ACK, WAIT_IDLE, DONE} state_t;
  state_t state, nxt;
  logic [2:0] csync;
  logic [1:0] dsync;
  logic [8:0] shreg;
  logic [3:0] bit_cnt;
  logic [IW-1:0] icnt;
  logic [TW-1:0] tcnt;
  logic fall, live, timeout, inh_done, last, err, data_nxt;
  assign fall = csync[2:1] == 2'b10;
  assign live = state inside {RTS, DATA, ACK, WAIT_IDLE};
  assign timeout = live && tcnt == TW'(TIMEOUT_CYCLES);
  assign inh_done = icnt == IW'(INHIBIT_CYCLES - 1);
  assign last = bit_cnt == 4'd8;
  assign tx_ready = state == IDLE;
  assign busy = !tx_ready;
  assign tx_done = state == DONE;
  assign tx_err = tx_done && err;
  // data_nxt is the data-line pull for the coming cycle; both pulls are registered so the pins never glitch
  always_comb begin
    nxt = state;
    data_nxt = 1'b0;
    case (state)
      IDLE:      nxt = tx_valid ? INHIBIT : IDLE;
      INHIBIT: begin
        nxt = inh_done ? RTS : INHIBIT;
        data_nxt = inh_done;
      end
      RTS: begin
        nxt = fall ? DATA : RTS;
        data_nxt = fall ? ~shreg[0] : 1'b1;
      end
      DATA: begin
        nxt = (fall && last) ? ACK : DATA;
        data_nxt = fall ? (~shreg[0] && !last) : ps2_data_pull;
      end
      ACK:       nxt = fall ? WAIT_IDLE : ACK;
      WAIT_IDLE: nxt = (csync[1] && dsync[1]) ? DONE : WAIT_IDLE;
      default:   nxt = IDLE;
    endcase
    if (timeout) begin
      nxt = DONE;
      data_nxt = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      csync <= '0;
      dsync <= '0;
      shreg <= '0;
      bit_cnt <= '0;
      icnt <= '0;
      tcnt <= '0;
      err <= 1'b0;
      ps2_clk_pull <= 1'b0;
      ps2_data_pull <= 1'b0;
    end else begin
      state <= nxt;
      csync <= {csync[1:0], ps2_clk};
      dsync <= {dsync[0], ps2_data};
      ps2_clk_pull <= nxt == INHIBIT;
      ps2_data_pull <= data_nxt;
      icnt <= (state == INHIBIT) ? icnt + IW'(1) : '0;
      tcnt <= (state == INHIBIT) ? '0 : (live && !timeout) ? tcnt + TW'(1) : tcnt;
      bit_cnt <= (state == RTS) ? '0 : (state == DATA && fall) ? bit_cnt + 4'd1 : bit_cnt;
      err <= (state == IDLE) ? 1'b0 : timeout ? 1'b1 : (state == ACK && fall) ? dsync[1] : err;
      if (tx_ready && tx_valid) shreg <= {~^tx_data, tx_data};
      else if (fall && (state == RTS || state == DATA)) shreg <= {1'b0, shreg[8:1]};
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized scoreboard bench with an open-drain PS/2 device model
module tb_ps2_host_tx;
  localparam int INH = 100;
  localparam int TMO = 50000;
  localparam int HP = 20;
  typedef struct packed {logic [7:0] d; logic err; logic rx;} exp_t;
  logic clk = 1'b0;
  logic clrn, tx_valid, tx_ready, busy, tx_done, tx_err, ps2_clk_pull, ps2_data_pull;
  logic [7:0] tx_data;
  logic dev_clk_low, dev_data_low, dev_busy, dev_abort, prev_done;
  logic ps2_clk, ps2_data;
  int dev_mode, dev_edges, checks, errors;
  exp_t exp_q[$];
  logic [10:0] dev_q[$];
  exp_t e;
  assign ps2_clk = !(ps2_clk_pull || dev_clk_low);
  assign ps2_data = !(ps2_data_pull || dev_data_low);
  always #5 clk = ~clk;
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_clk_pull(ps2_clk_pull), .ps2_data_pull(ps2_data_pull),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .tx_done(tx_done), .tx_err(tx_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2) == 0;
    return {1'b1, par, d, 1'b0};
  endfunction
  function automatic exp_t mk(input logic [7:0] d, input int mode);
    exp_t x;
    x.d = d;
    x.err = mode != 0;
    x.rx = mode != 2;
    return x;
  endfunction
  // device: after RTS clocks 11 times, samples on rising edges, acks on clock 11 (mode 0), naks (1) or stays silent (2)
  initial begin
    logic [10:0] fr;
    dev_clk_low = 0;
    dev_data_low = 0;
    dev_busy = 0;
    dev_edges = 0;
    forever begin
      wait (ps2_clk == 1'b0);
      wait (ps2_clk == 1'b1);
      repeat (5) @(negedge clk);
      if (dev_mode == 2 || ps2_data) continue;
      dev_busy = 1;
      dev_edges = 0;
      fr = '0;
      fr[0] = ps2_data;
      for (int i = 1; i <= 11; i++) begin
        repeat (HP) @(negedge clk);
        if (dev_abort) break;
        dev_clk_low = 1;
        dev_edges = i;
        chk("busy_mid", {30'd0, busy, tx_ready}, 32'd2);
        repeat (HP) @(negedge clk);
        if (dev_abort) break;
        dev_clk_low = 0;
        if (i <= 10) fr[i] = ps2_data;
        if (i == 10) begin
          dev_q.push_back(fr);
          if (dev_mode == 0) dev_data_low = 1;
        end
      end
      if (!dev_abort) repeat (HP) @(negedge clk);
      dev_clk_low = 0;
      dev_data_low = 0;
      dev_busy = 0;
    end
  end
  always @(negedge clk) begin
    if (clrn && tx_done) begin
      chk("done_pulse", {31'd0, prev_done}, 0);
      chk("pull_at_done", {30'd0, ps2_clk_pull, ps2_data_pull}, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done act=1 exp=0");
      end else begin
        e = exp_q.pop_front();
        chk("tx_err", {31'd0, tx_err}, {31'd0, e.err});
        if (e.rx) begin
          if (dev_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_missing act=none exp=%0h", ref_frame(e.d));
          end else chk("frame", {21'd0, dev_q.pop_front()}, {21'd0, ref_frame(e.d)});
        end
      end
    end
    prev_done = tx_done;
  end
  task automatic handshake(input logic [7:0] d);
    int i;
    @(negedge clk);
    tx_data = d;
    tx_valid = 1;
    for (i = 0; i < 60000 && !tx_ready; i++) @(negedge clk);
    chk("handshake", {31'd0, tx_ready}, 1);
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 60000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("done_wait", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    chk("idle_after", {28'd0, busy, tx_ready, ps2_clk_pull, ps2_data_pull}, 32'h4);
  endtask
  task automatic xfer(input logic [7:0] d, input int mode);
    dev_mode = mode;
    exp_q.push_back(mk(d, mode));
    handshake(d);
    tx_valid = 0;
    wait_done();
  endtask
  initial begin
    int n;
    logic [7:0] r;
    checks = 0;
    errors = 0;
    prev_done = 0;
    clrn = 0;
    tx_valid = 0;
    tx_data = 0;
    dev_mode = 0;
    dev_abort = 0;
    repeat (3) @(negedge clk);
    chk("reset_out", {26'd0, ps2_clk_pull, ps2_data_pull, tx_ready, busy, tx_done, tx_err}, 32'h8);
    clrn = 1;
    repeat (3) @(negedge clk);
    xfer(8'hED, 0);
    dev_mode = 0;
    exp_q.push_back(mk(8'h00, 0));
    exp_q.push_back(mk(8'hFF, 0));
    handshake(8'h00);
    handshake(8'hFF);
    tx_valid = 0;
    wait_done();
    xfer(8'($urandom), 1);
    dev_mode = 0;
    r = 8'($urandom);
    exp_q.push_back(mk(r, 0));
    dev_edges = 0;
    handshake(r);
    tx_valid = 0;
    for (int i = 0; i < 5000 && dev_edges < 3; i++) @(negedge clk);
    tx_data = 8'h12;
    tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
    wait_done();
    chk("ignored_extra", dev_q.size(), 0);
    dev_edges = 0;
    exp_q.push_back(mk(8'h00, 0));
    handshake(8'h00);
    tx_valid = 0;
    for (int i = 0; i < 5000 && dev_edges < 4; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("pull_before_rst", {31'd0, ps2_data_pull}, 1);
    #2;
    dev_abort = 1;
    clrn = 0;
    #1;
    chk("rst_async", {28'd0, ps2_clk_pull, ps2_data_pull, tx_ready, tx_done}, 32'h2);
    void'(exp_q.pop_front());
    for (int i = 0; i < 200 && dev_busy; i++) @(negedge clk);
    @(negedge clk);
    clrn = 1;
    dev_abort = 0;
    repeat (3) @(negedge clk);
    chk("ready_after_rst", {30'd0, tx_ready, busy}, 32'h2);
    xfer(8'h55, 0);
    for (int k = 0; k < 6; k++) xfer(8'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0);
    dev_mode = 2;
    r = 8'($urandom);
    exp_q.push_back(mk(r, 2));
    handshake(r);
    tx_valid = 0;
    for (int i = 0; i < 1000 && !ps2_data_pull; i++) @(negedge clk);
    n = 0;
    while (ps2_data_pull && n < 60000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(n >= TMO && n <= TMO + 1)) begin
      errors++;
      $display("FAIL timeout_len act=%0d exp=%0d..%0d", n, TMO, TMO + 1);
    end
    chk("timeout_same_cycle", {30'd0, ps2_clk_pull, tx_done}, 32'h1);
    wait_done();
    chk("queues_empty", exp_q.size() + dev_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
